core_mem_arbiter: RTL

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory request/response channel. Only one memory transaction is in flight
// at a time. Data normally has priority. An instruction request is granted
// once MAX_DSTREAK back-to-back data grants have gone by while it waited.
// A core flush that hits an in-flight fetch is absorbed by dropping that
// fetch's response, so the memory handshake is never abandoned half-way.
module core_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    // instruction fetch port
    input  logic                      i_req_valid,
    output logic                      i_req_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic                      i_flush,
    output logic                      i_rsp_valid,
    output logic [DATA_WIDTH-1:0]     i_rsp_data,

    // load/store port
    input  logic                      d_req_valid,
    output logic                      d_req_ready,
    input  logic [ADDR_WIDTH-1:0]     d_req_addr,
    input  logic                      d_req_we,
    input  logic [DATA_WIDTH/8-1:0]   d_req_be,
    input  logic [DATA_WIDTH-1:0]     d_req_wdata,
    output logic                      d_rsp_valid,
    output logic [DATA_WIDTH-1:0]     d_rsp_data,

    // shared memory port
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic [ADDR_WIDTH-1:0]     m_req_addr,
    output logic                      m_req_we,
    output logic [DATA_WIDTH/8-1:0]   m_req_be,
    output logic [DATA_WIDTH-1:0]     m_req_wdata,
    input  logic                      m_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     m_rsp_data
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0] DSTREAK_MAX = CNT_W'(MAX_DSTREAK);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Owner encoding; 0 is the reset value, so a cleared owner reads as fetch.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Streak counter increment that sticks at MAX_DSTREAK instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= DSTREAK_MAX) begin
            return DSTREAK_MAX;
        end
        return v + CNT_W'(1);
    endfunction

    // control state
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;
    logic              owner_nxt;
    logic              drop;
    logic              drop_nxt;
    logic [CNT_W-1:0]  dstreak;
    logic [CNT_W-1:0]  dstreak_nxt;

    // request captured at accept, replayed on the memory port
    logic [ADDR_WIDTH-1:0] req_addr_p1;
    logic                  req_we_p1;
    logic [BE_W-1:0]       req_be_p1;
    logic [DATA_WIDTH-1:0] req_wdata_p1;

    // decoded conditions
    logic is_idle;
    logic is_busy;
    logic i_eligible;
    logic starved;
    logic d_grant;
    logic i_grant;
    logic m_fire;
    logic rsp_fire;
    logic i_deliver;
    logic d_deliver;

    // ---- stage 0: arbitration and handshake decode ----

    // Pick the winner in IDLE; data wins unless a live fetch has been starved.
    always_comb begin
        is_idle    = (state == ST_IDLE);
        is_busy    = (state == ST_ISSUE) || (state == ST_WAIT);
        i_eligible = i_req_valid && !i_flush;
        starved    = i_eligible && (dstreak == DSTREAK_MAX);
        d_grant    = is_idle && d_req_valid && !starved;
        i_grant    = is_idle && i_eligible && !d_grant;
        m_fire     = (state == ST_ISSUE) && m_req_ready;
        rsp_fire   = (state == ST_WAIT) && m_rsp_valid;
        i_deliver  = rsp_fire && (owner == OWN_I) && !drop;
        d_deliver  = rsp_fire && (owner == OWN_D);
    end

    // Walk IDLE -> ISSUE -> WAIT -> IDLE, one transaction at a time.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (d_grant || i_grant) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_fire) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Track owner, the data-grant streak and the flushed-fetch drop flag.
    always_comb begin
        owner_nxt   = owner;
        dstreak_nxt = dstreak;
        drop_nxt    = drop;

        if (d_grant) begin
            owner_nxt = OWN_D;
        end else if (i_grant) begin
            owner_nxt = OWN_I;
        end

        // The streak only grows while a fetch is actually waiting, and any
        // idle cycle with no fetch pending forgets the history.
        if (i_grant) begin
            dstreak_nxt = '0;
        end else if (d_grant && i_req_valid) begin
            dstreak_nxt = sat_inc(dstreak);
        end else if (is_idle && !i_req_valid) begin
            dstreak_nxt = '0;
        end

        // The response that retires the transaction also retires the flag,
        // so a flush landing on that same cycle cannot leak into the next
        // fetch.
        if (rsp_fire) begin
            drop_nxt = 1'b0;
        end else if (is_busy && (owner == OWN_I) && i_flush) begin
            drop_nxt = 1'b1;
        end
    end

    // Drive client and memory ports; reset forces every handshake output low.
    always_comb begin
        i_req_ready = i_grant && !rst;
        d_req_ready = d_grant && !rst;

        m_req_valid = (state == ST_ISSUE) && !rst;
        m_req_addr  = req_addr_p1;
        m_req_we    = req_we_p1;
        m_req_be    = req_be_p1;
        m_req_wdata = req_wdata_p1;

        i_rsp_valid = i_deliver && !rst;
        d_rsp_valid = d_deliver && !rst;
        i_rsp_data  = i_rsp_valid ? m_rsp_data : '0;
        d_rsp_data  = d_rsp_valid ? m_rsp_data : '0;
    end

    // ---- stage 1: registered control and captured request ----

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_I;
            drop    <= 1'b0;
            dstreak <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            drop    <= drop_nxt;
            dstreak <= dstreak_nxt;
        end
    end

    // Capture the winning request; fetches are always full-word reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_p1  <= '0;
            req_we_p1    <= 1'b0;
            req_be_p1    <= '0;
            req_wdata_p1 <= '0;
        end else if (d_grant) begin
            req_addr_p1  <= d_req_addr;
            req_we_p1    <= d_req_we;
            req_be_p1    <= d_req_be;
            req_wdata_p1 <= d_req_wdata;
        end else if (i_grant) begin
            req_addr_p1  <= i_req_addr;
            req_we_p1    <= 1'b0;
            req_be_p1    <= '1;
            req_wdata_p1 <= '0;
        end
    end

    // ---- structural invariants ----

    a_rsp_exclusive : assert property (@(posedge clk)
        !(i_rsp_valid && d_rsp_valid));

    a_ready_only_idle : assert property (@(posedge clk) disable iff (rst)
        (state != ST_IDLE) |-> !(i_req_ready || d_req_ready));

    a_single_winner : assert property (@(posedge clk)
        !(i_req_ready && d_req_ready));

    a_state_legal : assert property (@(posedge clk) disable iff (rst)
        state != 2'd3);

    a_drop_is_fetch : assert property (@(posedge clk) disable iff (rst)
        drop |-> (owner == OWN_I));

    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (m_req_valid && !m_req_ready) |=>
            ($stable(m_req_addr) && $stable(m_req_we) &&
             $stable(m_req_be) && $stable(m_req_wdata)));

endmodule
